// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - RV32E writeback stage: ALU forward, load align/extend, timeout and misalignment faults
//
// Ports:
//   I_clk, I_rst_n                 clock (rising edge), asynchronous active-low reset
//   I_valid / O_ready              op handshake from execute; O_ready = IDLE
//   I_is_load, I_rd, I_result      op kind, destination, ALU/jump-link result
//   I_size, I_unsigned, I_addr_lo  load size (00 b, 01 h, 10 w), zero-extend, byte address [1:0]
//   I_mem_rvalid, I_mem_rdata      load response pulse and little-endian data word
//   O_regwen, O_rd, O_data         register file write port (O_regwen is a pulse)
//   O_pend_valid, O_pend_rd        outstanding load destination for hazard logic
//   O_fault                        pulse: bus timeout, misaligned load or reserved size

module writeback_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_valid,
    output logic        O_ready,
    input  logic        I_is_load,
    input  logic [3:0]  I_rd,
    input  logic [31:0] I_result,
    input  logic [1:0]  I_size,
    input  logic        I_unsigned,
    input  logic [1:0]  I_addr_lo,
    input  logic        I_mem_rvalid,
    input  logic [31:0] I_mem_rdata,
    output logic        O_regwen,
    output logic [3:0]  O_rd,
    output logic [31:0] O_data,
    output logic        O_pend_valid,
    output logic [3:0]  O_pend_rd,
    output logic        O_fault
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT_MEM
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    ld_rd_q, ld_rd_d;
    logic [1:0]    ld_size_q, ld_size_d;
    logic          ld_uns_q, ld_uns_d;
    logic [1:0]    ld_addr_q, ld_addr_d;
    logic          regwen_d, fault_d;
    logic [3:0]    rd_d;
    logic [31:0]   data_d;

    logic          illegal;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   aligned;

    assign O_ready      = (state_q == S_IDLE);
    assign O_pend_valid = (state_q == S_WAIT_MEM);
    assign O_pend_rd    = O_pend_valid ? ld_rd_q : 4'd0;

    // Upstream never issues a bus request for these, so they must not wait.
    assign illegal = (I_size == 2'b11)
                  || (I_size == 2'b01 && I_addr_lo[0])
                  || (I_size == 2'b10 && I_addr_lo != 2'b00);

    always_comb begin
        ld_byte = I_mem_rdata[{ld_addr_q, 3'b000} +: 8];
        ld_half = ld_addr_q[1] ? I_mem_rdata[31:16] : I_mem_rdata[15:0];
        case (ld_size_q)
            2'b00:   aligned = {{24{ld_byte[7] & ~ld_uns_q}}, ld_byte};
            2'b01:   aligned = {{16{ld_half[15] & ~ld_uns_q}}, ld_half};
            default: aligned = I_mem_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ld_rd_d   = ld_rd_q;
        ld_size_d = ld_size_q;
        ld_uns_d  = ld_uns_q;
        ld_addr_d = ld_addr_q;
        regwen_d  = 1'b0;
        fault_d   = 1'b0;
        rd_d      = O_rd;
        data_d    = O_data;
        case (state_q)
            S_IDLE: begin
                // Late rvalid after a timeout lands here and is ignored.
                if (I_valid) begin
                    if (!I_is_load) begin
                        regwen_d = (I_rd != 4'd0);
                        rd_d     = I_rd;
                        data_d   = I_result;
                    end else if (illegal) begin
                        fault_d = 1'b1;
                    end else begin
                        state_d   = S_WAIT_MEM;
                        cnt_d     = '0;
                        ld_rd_d   = I_rd;
                        ld_size_d = I_size;
                        ld_uns_d  = I_unsigned;
                        ld_addr_d = I_addr_lo;
                    end
                end
            end
            S_WAIT_MEM: begin
                // Data arriving in the timeout cycle takes priority over the fault.
                if (I_mem_rvalid) begin
                    regwen_d = (ld_rd_q != 4'd0);
                    rd_d     = ld_rd_q;
                    data_d   = aligned;
                    state_d  = S_IDLE;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    fault_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ld_rd_q   <= 4'd0;
            ld_size_q <= 2'b00;
            ld_uns_q  <= 1'b0;
            ld_addr_q <= 2'b00;
            O_regwen  <= 1'b0;
            O_rd      <= 4'd0;
            O_data    <= 32'd0;
            O_fault   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ld_rd_q   <= ld_rd_d;
            ld_size_q <= ld_size_d;
            ld_uns_q  <= ld_uns_d;
            ld_addr_q <= ld_addr_d;
            O_regwen  <= regwen_d;
            O_rd      <= rd_d;
            O_data    <= data_d;
            O_fault   <= fault_d;
        end
    end

endmodule
